// File: rtl/square_accumulate_reconstructor.sv
// Iterative squarer that rebuilds a radicand from a (root, remainder) pair and
// flags pairs that are not a canonical square-root result (remainder > 2*root).
module square_accumulate_reconstructor #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clk_en_i,
  input  logic                    data_valid_i,
  input  logic [DATA_WIDTH/2-1:0] root_i,
  input  logic [DATA_WIDTH/2:0]   remainder_i,
  output logic                    ready_o,
  output logic [DATA_WIDTH-1:0]   radicand_o,
  output logic                    invalid_o,
  output logic                    data_valid_o
);

  localparam int ROOT_W     = DATA_WIDTH / 2;
  localparam int REM_W      = ROOT_W + 1;
  localparam int ACC_W      = DATA_WIDTH + 1;
  localparam int ITERATIONS = ROOT_W;
  localparam int CNT_W      = $clog2(ITERATIONS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SQUARE = 2'd1,
    ST_ACCUM  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [ROOT_W-1:0]       root_q, root_d;
  logic [REM_W-1:0]        rem_q, rem_d;
  logic                    invalid_q, invalid_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic [DATA_WIDTH-1:0]   radicand_q, radicand_d;
  logic                    invalid_out_q, invalid_out_d;
  logic                    valid_q, valid_d;

  // Non-canonical when the remainder exceeds twice the root.
  function automatic logic non_canonical(input logic [ROOT_W-1:0] root,
                                         input logic [REM_W-1:0]  rem);
    non_canonical = (rem > {root, 1'b0});
  endfunction

  // State and output registers; reset overrides the clock enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      root_q        <= '0;
      rem_q         <= '0;
      invalid_q     <= 1'b0;
      cnt_q         <= '0;
      ready_q       <= 1'b1;
      radicand_q    <= '0;
      invalid_out_q <= 1'b0;
      valid_q       <= 1'b0;
    end else if (clk_en_i) begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      root_q        <= root_d;
      rem_q         <= rem_d;
      invalid_q     <= invalid_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      radicand_q    <= radicand_d;
      invalid_out_q <= invalid_out_d;
      valid_q       <= valid_d;
    end
  end

  // Next-state logic: capture, MSB-first shift-add, then add the remainder.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    root_d        = root_q;
    rem_d         = rem_q;
    invalid_d     = invalid_q;
    cnt_d         = cnt_q;
    radicand_d    = radicand_q;
    invalid_out_d = invalid_out_q;
    valid_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (data_valid_i) begin
          root_d    = root_i;
          rem_d     = remainder_i;
          acc_d     = '0;
          cnt_d     = CNT_W'(ITERATIONS - 1);
          invalid_d = non_canonical(root_i, remainder_i);
          state_d   = ST_SQUARE;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SQUARE: begin
        if (root_q[cnt_q]) begin
          acc_d = {acc_q[ACC_W-2:0], 1'b0} + ACC_W'(root_q);
        end else begin
          acc_d = {acc_q[ACC_W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(0)) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_SQUARE;
        end
      end
      ST_ACCUM: begin
        // Truncation gives the documented modulo-2^DATA_WIDTH wrap.
        radicand_d    = acc_q[DATA_WIDTH-1:0] + DATA_WIDTH'(rem_q);
        invalid_out_d = invalid_q;
        valid_d       = 1'b1;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  assign ready_o      = ready_q;
  assign radicand_o   = radicand_q;
  assign invalid_o    = invalid_out_q;
  assign data_valid_o = valid_q;

endmodule

// File: doc/square_accumulate_reconstructor.md
# square_accumulate_reconstructor

Iterative unsigned squarer that inverts the non-restoring square root unit. It rebuilds the radicand from a (root, remainder) pair as radicand = root² + remainder. It also flags pairs that are not a canonical square-root result, i.e. remainder > 2·root. It sits downstream of the square root unit as a round-trip checker, and it also serves as a standalone squarer with remainder set to zero.

## Interface
Parameters:
- DATA_WIDTH, 32, radicand width; must be a power of 2 and ≥ 4. Root width is DATA_WIDTH/2; remainder width is DATA_WIDTH/2+1.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset. One clock; reset is synchronous and active-high.
- clk_en_i  input  1  clock enable; low freezes every register, including outputs.
- data_valid_i  input  1  operands valid; sampled only in IDLE with clk_en_i high.
- root_i  input  DATA_WIDTH/2  unsigned root.
- remainder_i  input  DATA_WIDTH/2+1  unsigned remainder.
- ready_o  output  1  high exactly while in IDLE.
- radicand_o  output  DATA_WIDTH  root² + remainder, modulo 2^DATA_WIDTH.
- invalid_o  output  1  remainder_i > 2·root_i for the operand pair that produced radicand_o.
- data_valid_o  output  1  one-cycle pulse when radicand_o and invalid_o update.

## Operation
- ITERATIONS = DATA_WIDTH/2. The counter is $clog2(ITERATIONS) bits wide.
- Internal registers:
  - acc: DATA_WIDTH+1 bits.
  - root_q: DATA_WIDTH/2 bits.
  - rem_q: DATA_WIDTH/2+1 bits.
  - invalid_q.
  - counter.
- IDLE:
  - Transition: on data_valid_i, capture root_i and remainder_i, set acc = 0, counter = ITERATIONS−1, invalid_q = (remainder_i > {root_i,1'b0}), then go to SQUARE.
  - Operand capture happens only on that acceptance edge. Later input changes have no effect.
- SQUARE: MSB-first shift-add (Horner form).
  - acc ← (acc << 1) + (root_q[counter] ? root_q : 0).
  - Decrement counter. If counter == 0 on this edge, go to ACCUMULATE.
  - Exactly ITERATIONS cycles are spent in SQUARE.
- ACCUMULATE:
  - radicand_o ← (acc + rem_q)[DATA_WIDTH−1:0].
  - invalid_o ← invalid_q.
  - data_valid_o ← 1.
  - Go to IDLE.
- data_valid_o is cleared on every enabled edge other than the ACCUMULATE edge.
- Width rules:
  - root² fits in DATA_WIDTH bits.
  - For canonical pairs, root² + remainder ≤ 2^DATA_WIDTH − 1, so there is no wrap.
  - The only wrapping input is root = 2^(DATA_WIDTH/2)−1 with remainder = 2^(DATA_WIDTH/2+1)−1, which gives 0. invalid_o is 1 in that case.
- data_valid_i asserted outside IDLE is ignored; it is not queued.
- radicand_o and invalid_o hold their value until the next ACCUMULATE edge.
- Reset values: state IDLE, ready_o 1, radicand_o 0, invalid_o 0, data_valid_o 0.
- Reset clears acc, counter, root_q, rem_q and invalid_q to 0.
- Reset has priority over clk_en_i.
- Reset mid-operation aborts the computation and emits no data_valid_o pulse.

## Timing
- Acceptance edge = the edge where IDLE, data_valid_i = 1 and clk_en_i = 1.
- data_valid_o is high in the cycle following enabled edge number ITERATIONS+1 after the acceptance edge. For DATA_WIDTH=32, that is 17 enabled edges.
- Cycles with clk_en_i low stretch the latency one-for-one. data_valid_o stays high across disabled cycles and clears on the next enabled edge.
- ready_o falls the cycle after acceptance and rises again with data_valid_o.
- Back-to-back operation: a new operand can be accepted in the same cycle data_valid_o is high. Throughput is one result per ITERATIONS+2 cycles.
- Simultaneous events:
  - rst_i together with data_valid_i: reset wins and nothing is accepted.
  - clk_en_i low together with data_valid_i: nothing is accepted.

## Test plan
All cases use DATA_WIDTH=32.
- root 0xFFFF, rem 0x1FFFE -> radicand_o 0xFFFFFFFF, invalid_o 0, data_valid_o 17 edges after acceptance, for one cycle.
- root 0x0000, rem 0; then root 12, rem 0 -> radicand_o 0, invalid_o 0; then 144, invalid_o 0.
- root 3, rem 7 -> radicand_o 16, invalid_o 1. Then root 0xFFFF, rem 0x1FFFF -> radicand_o 0 (wrap), invalid_o 1.
- Handshake:
  - Pulse data_valid_i during SQUARE with different operands -> ignored; the first result is unchanged.
  - Assert data_valid_i in the data_valid_o cycle -> accepted; the second result follows 18 cycles later.
- Hold clk_en_i low for 5 cycles mid-SQUARE -> result is correct, latency is 22 cycles, and outputs are frozen during the stall.
- Assert rst_i at SQUARE cycle 8 -> no data_valid_o pulse, outputs 0, ready_o 1 the next cycle. Then root 0x1234, rem 0x100 -> radicand_o 0x014B5A90 plus 0x100 = 0x014B5B90.
